reg_file_mp: RTL and testbench

Parametrised successor to the core's 32x32 register file, for the pipelined RV32I/RV32E variants.
- Configurable data width, register count and number of combinational read ports.
- Write-first bypass on reads.
- Hardware clear sequencer, so storage maps to RAM-style arrays without per-bit reset.
- Pending-write scoreboard, so the hazard unit can stall on RAW hazards.
- Sits between decode (reads, issue) and writeback (write port).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 43 ++++
 rtl/reg_file_mp.sv | 116 +++++++++++
 tb/tb_reg_file_mp.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int MAX_XLEN  = 64;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Zero-extension leaves reduction XOR unchanged, so narrower words can share this.
  function automatic logic even_parity(input logic [MAX_XLEN-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module rf_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_idx,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]  pending
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nx;

  // Set is applied after clear so a newer producer stays outstanding.
  always_comb begin
    pend_nx = pend;
    if (wb_en)
      pend_nx[wb_idx] = 1'b0;
    if (set_en)
      pend_nx[set_idx] = 1'b1;
    pend_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pend <= '0;
    else
      pend <= pend_nx;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] a;
    assign a          = rd_addr[k*AW +: AW];
    assign pending[k] = pend[a] & ~(wb_en && (wb_idx == a));
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with write-first bypass, clear sequencer
// and RAW scoreboard. Optional per-register parity enabled by REGFILE_PARITY_EN.
module reg_file_mp import regfile_pkg::*; #(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                busy,
  output logic [NRD-1:0]      rd_err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   clr_idx;
  logic [AW-1:0]   clr_idx_nx;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;
  logic            sb_wb_en;
  logic            sb_set_en;
  logic [NRD-1:0]  sb_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= AW'(1);
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  // Register 0 is never stored, so the sweep starts at 1 and ends on the top register.
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    busy       = rst;
    case (state)
      ST_CLEAR: begin
        busy       = 1'b1;
        clr_idx_nx = clr_idx + AW'(1);
        if (clr_idx == LAST_IDX)
          state_nx = ST_IDLE;
      end
      ST_IDLE: ;
      default: begin
        busy     = 1'b1;
        state_nx = ST_CLEAR;
      end
    endcase
  end

  assign wr_en     = we && (wa != '0) && !busy;
  assign sb_wb_en  = we && (wa != '0) && !busy;
  assign sb_set_en = iss_valid && (iss_rd != '0) && !busy;

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)
      regs[clr_idx] <= '0;
    else if (wr_en)
      regs[wa] <= wd;
  end

`ifdef REGFILE_PARITY_EN
  logic [NREGS-1:0] parity_mem;

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)
      parity_mem[clr_idx] <= 1'b0;
    else if (wr_en)
      parity_mem[wa] <= even_parity(MAX_XLEN'(wd));
  end
`else
  assign rd_err = '0;
`endif

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set_en),
    .set_idx (iss_rd),
    .wb_en   (sb_wb_en),
    .wb_idx  (wa),
    .rd_addr (rd_addr),
    .pending (sb_pend)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rd_addr[k*AW +: AW];
    assign hit = we && (wa == a) && (wa != '0);
    assign rd_data[k*XLEN +: XLEN] = (busy || (a == '0)) ? '0 : (hit ? wd : regs[a]);
    assign rd_pending[k] = !busy && sb_pend[k];
`ifdef REGFILE_PARITY_EN
    assign rd_err[k] = !busy && (a != '0) && !hit && (parity_mem[a] ^ (^regs[a]));
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: vector table plus reset / mid-clear / parity sequences.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pending;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                busy;
  logic [NRD-1:0]      rd_err;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .busy       (busy),
    .rd_err     (rd_err)
  );

  typedef struct {
    string           name;
    logic            rst;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            iv;
    logic [AW-1:0]   ir;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic            busy;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic [1:0]      pend;
    logic [1:0]      err;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string name, logic r, logic w, int wa_i, logic [XLEN-1:0] wd_i,
                              logic iv, int ir_i, int a0_i, int a1_i, logic b,
                              logic [XLEN-1:0] d0, logic [XLEN-1:0] d1, logic [1:0] p,
                              logic [1:0] e = 2'b00);
    vec_t v;
    v.name = name; v.rst = r; v.we = w; v.wa = AW'(wa_i); v.wd = wd_i;
    v.iv = iv; v.ir = AW'(ir_i); v.a0 = AW'(a0_i); v.a1 = AW'(a1_i);
    v.busy = b; v.d0 = d0; v.d1 = d1; v.pend = p; v.err = e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    we        = v.we;
    wa        = v.wa;
    wd        = v.wd;
    iss_valid = v.iv;
    iss_rd    = v.ir;
    rd_addr   = {v.a1, v.a0};
    exp_q.push_back(v);
  endtask

  task automatic cmp(input string nm, input string field, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", nm, field, act, expv);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = exp_q.pop_front();
    cmp(e.name, "busy",    XLEN'(busy),       XLEN'(e.busy));
    cmp(e.name, "rd_data0", rd_data[0 +: XLEN],    e.d0);
    cmp(e.name, "rd_data1", rd_data[XLEN +: XLEN], e.d1);
    cmp(e.name, "rd_pending", XLEN'(rd_pending), XLEN'(e.pend));
    cmp(e.name, "rd_err",  XLEN'(rd_err),     XLEN'(e.err));
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

`ifdef REGFILE_PARITY_EN
  logic [NREGS-1:0] pm;
`endif

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0; rd_addr = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++)
      step(mk("reset", 1, 0, 0, 0, 0, 0, 3, 5, 1, 0, 0, 2'b00));

    // A write attempted during the whole clear sweep must be dropped.
    for (int i = 0; i < NREGS - 1; i++)
      step(mk("clear_busy", 0, 1, 5, 32'h1234, 0, 0, 5, 0, 1, 0, 0, 2'b00));
    step(mk("busy_fall", 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 2'b00));

    for (int a = 0; a < NREGS; a++)
      step(mk("zero_scan", 0, 0, 0, 0, 0, 0, a, NREGS - 1 - a, 0, 0, 0, 2'b00));

    tbl.push_back(mk("wr_bypass",  0, 1,  3, 32'hDEADBEEF, 0,  0,  3,  0, 0, 32'hDEADBEEF, 0, 2'b00));
    tbl.push_back(mk("wr_hold",    0, 0,  0, 0,            0,  0,  3,  3, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk("x0_write",   0, 1,  0, 32'hFFFFFFFF, 1,  0,  0,  0, 0, 0, 0, 2'b00));
    tbl.push_back(mk("x0_after",   0, 0,  0, 0,            0,  0,  0,  3, 0, 0, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk("iss7",       0, 0,  0, 0,            1,  7,  7,  3, 0, 0, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk("pend7",      0, 0,  0, 0,            0,  0,  7,  7, 0, 0, 0, 2'b11));
    tbl.push_back(mk("wb_iss7",    0, 1,  7, 32'h77,       1,  7,  7,  7, 0, 32'h77, 32'h77, 2'b00));
    tbl.push_back(mk("still7",     0, 0,  0, 0,            0,  0,  7,  7, 0, 32'h77, 32'h77, 2'b11));
    tbl.push_back(mk("wb7",        0, 1,  7, 32'h88,       0,  0,  7,  0, 0, 32'h88, 0, 2'b00));
    tbl.push_back(mk("clear7",     0, 0,  0, 0,            0,  0,  7,  7, 0, 32'h88, 32'h88, 2'b00));
    tbl.push_back(mk("wb_nopend",  0, 1,  4, 32'h44,       0,  0,  0,  4, 0, 0, 32'h44, 2'b00));
    tbl.push_back(mk("read4",      0, 0,  0, 0,            0,  0,  4,  4, 0, 32'h44, 32'h44, 2'b00));
    tbl.push_back(mk("iss10",      0, 0,  0, 0,            1, 10, 10, 11, 0, 0, 0, 2'b00));
    tbl.push_back(mk("iss11",      0, 0,  0, 0,            1, 11, 10, 11, 0, 0, 0, 2'b01));
    tbl.push_back(mk("both_pend",  0, 0,  0, 0,            0,  0, 10, 11, 0, 0, 0, 2'b11));
    tbl.push_back(mk("wb10",       0, 1, 10, 32'h1010,     0,  0, 10, 11, 0, 32'h1010, 0, 2'b10));
    tbl.push_back(mk("after_wb10", 0, 0,  0, 0,            0,  0, 10, 11, 0, 32'h1010, 0, 2'b10));
    tbl.push_back(mk("wr12",       0, 1, 12, 32'hA5A5A5A5, 0,  0, 12, 31, 0, 32'hA5A5A5A5, 0, 2'b00));
    tbl.push_back(mk("wr31",       0, 1, 31, 32'h31313131, 0,  0, 12, 31, 0, 32'hA5A5A5A5, 32'h31313131, 2'b00));
    tbl.push_back(mk("read_top",   0, 0,  0, 0,            0,  0, 31, 12, 0, 32'h31313131, 32'hA5A5A5A5, 2'b00));
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);

    // Reset again, then interrupt the sweep after ten cycles.
    step(mk("rst2", 1, 0, 0, 0, 0, 0, 12, 31, 1, 0, 0, 2'b00));
    for (int i = 0; i < 10; i++)
      step(mk("clear_part", 0, 0, 0, 0, 0, 0, 12, 31, 1, 0, 0, 2'b00));
    step(mk("rst_mid", 1, 0, 0, 0, 0, 0, 12, 31, 1, 0, 0, 2'b00));
    for (int i = 0; i < NREGS - 1; i++)
      step(mk("reclear_busy", 0, 1, 12, 32'hFFFF, 1, 12, 12, 31, 1, 0, 0, 2'b00));
    step(mk("reclear_done", 0, 0, 0, 0, 0, 0, 12, 31, 0, 0, 0, 2'b00));
    step(mk("sb_reset",     0, 0, 0, 0, 0, 0, 10, 11, 0, 0, 0, 2'b00));

`ifdef REGFILE_PARITY_EN
    step(mk("par_wr9",   0, 1, 9, 32'h1, 0, 0, 0, 9, 0, 0, 32'h1, 2'b00, 2'b00));
    pm = dut.parity_mem;
    pm[9] = ~pm[9];
    force dut.parity_mem = pm;
    step(mk("par_err",   0, 0, 0, 0,     0, 0, 0, 9, 0, 0, 32'h1, 2'b00, 2'b10));
    release dut.parity_mem;
    step(mk("par_rewr",  0, 1, 9, 32'h1, 0, 0, 0, 9, 0, 0, 32'h1, 2'b00, 2'b00));
    step(mk("par_clean", 0, 0, 0, 0,     0, 0, 0, 9, 0, 0, 32'h1, 2'b00, 2'b00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
